// File: rtl/bopit_pkg.sv
// Shared types and constants for the Bop-it round sequencer: state enum,
// letter codes, score ceiling and LFSR constants.
package bopit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROMPT = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HIT    = 3'd3,
        ST_MISS   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [2:0] ACT_NONE = 3'd0;
    localparam logic [2:0] ACT_L    = 3'd1;
    localparam logic [2:0] ACT_C    = 3'd2;
    localparam logic [2:0] ACT_R    = 3'd3;
    localparam logic [2:0] ACT_U    = 3'd4;
    localparam logic [2:0] ACT_D    = 3'd5;

    localparam logic [6:0]  SCORE_MAX = 7'd99;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois step; a nonzero seed never collapses to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Fold the 3-bit draw onto the five letters (5,6,7 reuse R,U,D).
    function automatic logic [2:0] letter_of(input logic [2:0] v);
        return (v < 3'd5) ? (v + 3'd1) : (v - 3'd2);
    endfunction

    function automatic logic [4:0] act_bit(input logic [2:0] l);
        logic [4:0] b;
        b = 5'b00000;
        case (l)
            ACT_L:   b = 5'b00001;
            ACT_C:   b = 5'b00010;
            ACT_R:   b = 5'b00100;
            ACT_U:   b = 5'b01000;
            ACT_D:   b = 5'b10000;
            default: b = 5'b00000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bopit_round_sequencer_if.sv
// Player/display side bundle of the round sequencer. The slave modport is the
// sequencer itself; the master modport is whatever drives start and the buttons.
interface bopit_round_sequencer_if;
    // start and act_pulse are single-cycle strobes sampled on every rising edge
    // with no back-pressure; every other signal is a registered level.
    logic       start;
    logic [4:0] act_pulse;
    logic [2:0] letter;
    logic [6:0] score;
    logic [6:0] high_score;
    logic [1:0] lives;
    logic       flash;
    logic       busy;
    logic       game_over;

    modport master (
        output start, act_pulse,
        input  letter, score, high_score, lives, flash, busy, game_over
    );

    modport slave (
        input  start, act_pulse,
        output letter, score, high_score, lives, flash, busy, game_over
    );
endinterface

// File: rtl/bopit_round_sequencer_ms_tick.sv
// Millisecond prescaler: counts 0..DIV-1 and raises tick on the wrap count.
// A synchronous clear restarts the millisecond from zero.
module ms_tick #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/bopit_round_sequencer.sv
// Bop-it game-round scheduler: prompts a random action, times the shrinking
// response window, keeps score/lives. Optional macro: BOPIT_HIGH_SCORE_EN.
module bopit_round_sequencer
    import bopit_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int WINDOW_INIT_MS = 2000,
    parameter int WINDOW_MIN_MS  = 500,
    parameter int WINDOW_STEP_MS = 100,
    parameter int FEEDBACK_MS    = 500,
    parameter int MAX_LIVES      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    bopit_round_sequencer_if.slave bus,
    output state_t                dbg_state
);
    localparam int          TICK_DIV = CLK_HZ / 1000;
    localparam logic [15:0] W_INIT   = 16'(WINDOW_INIT_MS);
    localparam logic [15:0] W_MIN    = 16'(WINDOW_MIN_MS);
    localparam logic [15:0] W_STEP   = 16'(WINDOW_STEP_MS);
    localparam logic [15:0] FB_MS    = 16'(FEEDBACK_MS);
    localparam logic [1:0]  LIVES0   = 2'(MAX_LIVES);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic [15:0] window_q;
    logic [15:0] ms_q;
    logic [2:0]  letter_q;
    logic [6:0]  score_q;
    logic [1:0]  lives_q;
    logic        flash_q, busy_q, over_q;
    logic        tick, ms_last, enter, presc_clr;
    logic [4:0]  want;

    assign want      = act_bit(letter_q);
    assign ms_last   = tick && (ms_q == 16'd1);
    assign enter     = (state_d != state_q);
    assign presc_clr = enter && (state_d inside {ST_WAIT, ST_HIT, ST_MISS});

    ms_tick #(.DIV(TICK_DIV)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .tick (tick)
    );

    // A press in WAIT outranks the timeout, even on the final tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_OVER: if (bus.start) state_d = ST_PROMPT;
            ST_PROMPT:        state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.act_pulse == want)         state_d = ST_HIT;
                else if (bus.act_pulse != 5'b0)    state_d = ST_MISS;
                else if (ms_last)                  state_d = ST_MISS;
            end
            ST_HIT:           if (ms_last) state_d = ST_PROMPT;
            ST_MISS: begin
                if (lives_q == 2'd0)  state_d = ST_OVER;
                else if (ms_last)     state_d = ST_PROMPT;
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            window_q <= W_INIT;
            ms_q     <= '0;
            letter_q <= ACT_NONE;
            score_q  <= '0;
            lives_q  <= '0;
            flash_q  <= 1'b0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_next(lfsr_q);
            busy_q  <= !(state_d inside {ST_IDLE, ST_OVER});
            flash_q <= (state_d inside {ST_MISS, ST_OVER});
            over_q  <= (state_d == ST_OVER);
            if (tick && (ms_q != 16'd0)) ms_q <= ms_q - 16'd1;
            if (enter) begin
                case (state_d)
                    ST_PROMPT: begin
                        if (state_q inside {ST_IDLE, ST_OVER}) begin
                            score_q  <= '0;
                            lives_q  <= LIVES0;
                            window_q <= W_INIT;
                        end
                    end
                    ST_WAIT: begin
                        letter_q <= letter_of(lfsr_q[2:0]);
                        ms_q     <= window_q;
                    end
                    ST_HIT: begin
                        if (score_q < SCORE_MAX) score_q <= score_q + 7'd1;
                        window_q <= (window_q >= W_MIN + W_STEP) ? (window_q - W_STEP) : W_MIN;
                        letter_q <= ACT_NONE;
                        ms_q     <= FB_MS;
                    end
                    ST_MISS: begin
                        lives_q  <= lives_q - 2'd1;
                        letter_q <= ACT_NONE;
                        ms_q     <= FB_MS;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOPIT_HIGH_SCORE_EN
    logic [6:0] high_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            high_q <= '0;
        end else if (enter && (state_d == ST_OVER) && (score_q > high_q)) begin
            high_q <= score_q;
        end
    end

    assign bus.high_score = high_q;
`else
    assign bus.high_score = '0;
`endif

    assign bus.letter    = letter_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.flash     = flash_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = over_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_bopit_round_sequencer.sv
// Bench for bopit_round_sequencer: directed games plus random play, all checked
// each cycle against a cycle-count model of the game rules.
module tb_bopit_round_sequencer;
    import bopit_pkg::*;

    localparam int CLK_HZ = 1000;
    localparam int CPM    = CLK_HZ / 1000;
    localparam int FB_MS  = 2;
    localparam int W_INIT = 2000;
    localparam int W_MIN  = 500;
    localparam int W_STEP = 100;
    localparam int LIVES  = 3;
`ifdef BOPIT_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    always #5 clk = ~clk;

    bopit_round_sequencer_if bus ();

    bopit_round_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .FEEDBACK_MS (FB_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_PROMPT = 1, P_WAIT = 2, P_HIT = 3, P_MISS = 4, P_OVER = 5;

    int          m_phase, m_left, m_window, m_letter, m_score, m_hs, m_lives;
    logic [15:0] m_lfsr;
    bit          m_valid = 1'b0;
    int          letter_tbl [8] = '{1, 2, 3, 4, 5, 3, 4, 5};

    function automatic logic [4:0] bit_of(input int l);
        logic [4:0] one;
        one = 5'b00001;
        return (l >= 1 && l <= 5) ? (one << (l - 1)) : 5'b00000;
    endfunction

    always @(posedge clk) begin
        int v;
        v = int'(m_lfsr[2:0]);
        if (rst) begin
            m_valid  = 1'b1;
            m_phase  = P_IDLE;
            m_left   = 0;
            m_window = W_INIT;
            m_letter = 0;
            m_score  = 0;
            m_hs     = 0;
            m_lives  = 0;
            m_lfsr   = 16'hACE1;
        end else if (m_valid) begin
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            case (m_phase)
                P_IDLE, P_OVER: if (bus.start) begin
                    m_score = 0; m_lives = LIVES; m_window = W_INIT; m_phase = P_PROMPT;
                end
                P_PROMPT: begin
                    m_letter = letter_tbl[v]; m_left = m_window * CPM; m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (bus.act_pulse == bit_of(m_letter)) begin
                        m_score  = (m_score < 99) ? m_score + 1 : 99;
                        m_window = (m_window - W_STEP < W_MIN) ? W_MIN : m_window - W_STEP;
                        m_letter = 0; m_left = FB_MS * CPM; m_phase = P_HIT;
                    end else if (bus.act_pulse != 5'b0 || m_left == 1) begin
                        m_lives = m_lives - 1; m_letter = 0; m_left = FB_MS * CPM; m_phase = P_MISS;
                    end else begin
                        m_left--;
                    end
                end
                P_HIT: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_PROMPT;
                end
                P_MISS: begin
                    if (m_lives == 0) begin
                        m_phase = P_OVER;
                        if (HS_EN && m_score > m_hs) m_hs = m_score;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_phase = P_PROMPT;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic state_t model_state(input int p);
        case (p)
            P_PROMPT: return ST_PROMPT;
            P_WAIT:   return ST_WAIT;
            P_HIT:    return ST_HIT;
            P_MISS:   return ST_MISS;
            P_OVER:   return ST_OVER;
            default:  return ST_IDLE;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("state",      int'(dbg_state),      int'(model_state(m_phase)));
            check("letter",     int'(bus.letter),     m_letter);
            check("score",      int'(bus.score),      m_score);
            check("high_score", int'(bus.high_score), m_hs);
            check("lives",      int'(bus.lives),      m_lives);
            check("busy",       int'(bus.busy),       int'(m_phase inside {P_PROMPT, P_WAIT, P_HIT, P_MISS}));
            check("flash",      int'(bus.flash),      int'(m_phase inside {P_MISS, P_OVER}));
            check("game_over",  int'(bus.game_over),  int'(m_phase == P_OVER));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic press(input logic [4:0] v);
        bus.act_pulse = v;
        step();
        bus.act_pulse = 5'b0;
    endtask

    task automatic wait_state(input state_t st, input string name);
        int n;
        n = 0;
        while (dbg_state != st && n < 5000) begin
            step();
            n++;
        end
        if (dbg_state != st) begin
            check(name, int'(dbg_state), int'(st));
            finish_run();
        end
    endtask

    task automatic do_hit(input int max_delay);
        wait_state(ST_WAIT, "reach_wait");
        repeat ($urandom_range(0, max_delay)) step();
        press(bit_of(int'(bus.letter)));
    endtask

    task automatic let_timeout(input int want);
        int n;
        wait_state(ST_WAIT, "reach_wait");
        exp_q.push_back(16'(want));
        n = 0;
        while (dbg_state == ST_WAIT && n < 5000) begin
            step();
            n++;
        end
        check("wait_len", n, int'(exp_q.pop_front()));
    endtask

    task automatic wrong_press(input bit plus_correct);
        int i;
        wait_state(ST_WAIT, "reach_wait");
        i = int'(bus.letter) - 1;
        if (plus_correct) press(bit_of(i + 1) | bit_of(((i + 2) % 5) + 1));
        else              press(bit_of(((i + 1) % 5) + 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start     = 1'b0;
        bus.act_pulse = 5'b0;
        rst           = 1'b1;
        repeat (3) step();
        check("rst_state", int'(dbg_state), int'(ST_IDLE));
        check("rst_score", int'(bus.score), 0);
        check("rst_lives", int'(bus.lives), 0);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_flash", int'(bus.flash), 0);
        rst = 1'b0;
        press(5'b00001);
        check("idle_press_score", int'(bus.score), 0);

        // Game 1: timeout, four hits, timeout, wrong press -> over with 4.
        pulse_start();
        let_timeout(2000);
        check("miss_lives", int'(bus.lives), 2);
        check("miss_flash", int'(bus.flash), 1);
        do_hit(6);
        check("first_hit_score", int'(bus.score), 1);
        repeat (3) do_hit(6);
        let_timeout(1600);
        wrong_press(1'b0);
        check("last_miss_lives", int'(bus.lives), 0);
        step();
        check("over_flag", int'(bus.game_over), 1);
        check("over_high", int'(bus.high_score), HS_EN ? 4 : 0);

        // Game 2: restart from OVER, end with score 2.
        pulse_start();
        check("restart_busy",  int'(bus.busy),  1);
        check("restart_score", int'(bus.score), 0);
        repeat (2) do_hit(6);
        wrong_press(1'b1);
        check("multi_bit_lives", int'(bus.lives), 2);
        wrong_press(1'b0);
        let_timeout(1800);
        wait_state(ST_OVER, "reach_over");
        check("high_kept", int'(bus.high_score), HS_EN ? 4 : 0);

        // Game 3: window floor, score saturation, press on the final tick.
        pulse_start();
        repeat (15) do_hit(4);
        let_timeout(500);
        repeat (90) do_hit(4);
        check("score_sat", int'(bus.score), 99);
        wait_state(ST_WAIT, "reach_wait");
        repeat (499) step();
        press(bit_of(int'(bus.letter)));
        check("final_tick_hit", int'(dbg_state), int'(ST_HIT));

        // Reset in the middle of a WAIT.
        wait_state(ST_WAIT, "reach_wait");
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state",  int'(dbg_state),      int'(ST_IDLE));
        check("midrst_score",  int'(bus.score),      0);
        check("midrst_letter", int'(bus.letter),     0);
        check("midrst_lives",  int'(bus.lives),      0);
        check("midrst_high",   int'(bus.high_score), 0);

        // Random play, including presses and starts outside their states.
        for (int k = 0; k < 4000; k++) begin
            int r;
            bus.start = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 9);
            if (r < 3)       bus.act_pulse = bit_of(int'(bus.letter));
            else if (r == 3) bus.act_pulse = 5'($urandom_range(1, 31));
            else             bus.act_pulse = 5'b0;
            step();
        end
        bus.start     = 1'b0;
        bus.act_pulse = 5'b0;
        step();
        finish_run();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d miscompares so far", n_bad);
        $fatal(1);
    end
endmodule

// File: doc/bopit_round_sequencer.md
# bopit_round_sequencer

Game-round scheduler for the Bop-it datapath. It owns the game state machine: it picks a pseudo-random action, presents it as a letter code to the display controller, and times the response window, which shrinks as the score rises. It judges the player's debounced action pulses, maintains score, lives and high score, and drives the flash request consumed by the blink/LED multiplexer and digit controller.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency, used to derive the 1 ms tick.
- `WINDOW_INIT_MS`, 2000: response window at game start.
- `WINDOW_MIN_MS`, 500: floor of the response window.
- `WINDOW_STEP_MS`, 100: window reduction per hit.
- `FEEDBACK_MS`, 500: hold time of the HIT/MISS feedback.
- `MAX_LIVES`, 3: misses allowed per game, range 1..3.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  single-cycle pulse; starts a game from IDLE or OVER, ignored elsewhere.
- `act_pulse`  in  5  one-cycle debounced action pulses; bit0 L, bit1 C, bit2 R, bit3 U, bit4 D.
- `letter`  out  3  prompted action; 0 means none, 1..5 map to act_pulse bit0..bit4.
- `score`  out  7  current score, 0..99.
- `high_score`  out  7  best score since reset.
- `lives`  out  2  remaining lives.
- `flash`  out  1  high in MISS and OVER.
- `busy`  out  1  high in every state except IDLE and OVER.
- `game_over`  out  1  high in OVER.

## Operation
- States: IDLE, PROMPT, WAIT, HIT, MISS, OVER.
- Reset: state IDLE, all outputs 0, window = `WINDOW_INIT_MS`, LFSR = 16'hACE1, prescaler 0. Reset overrides any state, including mid-WAIT.
- IDLE or OVER with `start`: score 0, lives = `MAX_LIVES`, window = `WINDOW_INIT_MS`, go to PROMPT.
- PROMPT, one cycle:
  - Compute v = lfsr[2:0]. Set letter = v+1 if v<5, otherwise v-2.
  - Load the ms counter with window, clear the prescaler, go to WAIT.
- WAIT, judged in this priority order:
  - act_pulse equal to exactly the one-hot bit of letter: go to HIT.
  - Any other nonzero act_pulse, including multiple bits: go to MISS.
  - 1 ms tick arriving while the counter equals 1: go to MISS (timeout).
  - A press in the same cycle as the final tick is judged as a press.
- HIT:
  - On entry: score+1, saturating at 99. Window decreases by `WINDOW_STEP_MS`, clamped to `WINDOW_MIN_MS`. letter = 0.
  - Hold `FEEDBACK_MS`, then go to PROMPT.
- MISS:
  - On entry: lives-1, letter = 0, flash = 1.
  - If the new lives value is 0, go to OVER immediately.
  - Otherwise hold `FEEDBACK_MS`, then go to PROMPT.
- OVER:
  - On entry: if score > high_score, high_score = score.
  - flash = 1, game_over = 1. Score is held for display.
- act_pulse is ignored outside WAIT.
- LFSR: 16-bit Galois, taps 0xB400, advances every cycle in every state. It never reaches zero.
- Prescaler: counts 0..CLK_HZ/1000-1 and emits a one-cycle tick at wrap. Cleared on entering WAIT, HIT or MISS.

## Timing
- All outputs are registered and update on the edge that enters a state.
- letter is valid from the cycle after PROMPT.
- WAIT with no press lasts exactly window×CLK_HZ/1000 cycles. MISS is entered on the following edge.
- A correct press at cycle t gives HIT and score+1 visible at t+1.
- HIT/MISS feedback lasts FEEDBACK_MS×CLK_HZ/1000 cycles; PROMPT follows for one cycle.
- A `start` pulse in OVER gives busy=1 and score=0 on the next cycle.

## Configuration
- `BOPIT_HIGH_SCORE_EN` defined: high-score register present and updated on OVER entry as described.
- Not defined: the register is removed and high_score is tied to 0.

## Structure
- Package `bopit_pkg` holds:
  - the state enum;
  - letter codes ACT_NONE, ACT_L, ACT_C, ACT_R, ACT_U, ACT_D;
  - SCORE_MAX = 99;
  - the LFSR seed and tap constants.
- Sub-module `ms_tick` holds the prescaler, with a synchronous clear input and a tick output.

## Test plan
Benches use `CLK_HZ`=1000 (1 tick per cycle), `FEEDBACK_MS`=2, and the default window parameters.
- Reset held 3 cycles: all outputs 0 and state IDLE. A pulse on act_pulse 5'b00001 leaves score at 0.
- Correct press:
  - Stimulus: `start`, then in WAIT a one-hot press matching letter.
  - Response: score=1 next cycle, window 1900. The next WAIT lasts exactly 1900 cycles if untouched.
- Timeout and wrong input:
  - No press: MISS on cycle 2001 of WAIT, lives 3 to 2, flash=1.
  - Wrong single bit, or the correct bit plus another bit: MISS, lives decremented.
- Game over:
  - Score 4 then 3 misses: game_over=1, high_score=4.
  - New game ending with score 2: high_score stays 4.
  - With `BOPIT_HIGH_SCORE_EN` undefined, high_score stays 0.
- Window and score limits:
  - After 15 hits, window stays 500.
  - 105 consecutive hits: score stops at 99.
- Reset mid-WAIT, and a press coinciding with the final tick:
  - Reset mid-WAIT: IDLE and outputs 0 on the next cycle.
  - Correct press on the final tick: HIT.
